sram_arbiter: RTL and testbench

Two-port arbiter that shares the single QSPI SRAM controller between the UART host bridge (host port, H) and the Levenshtein engine (engine port, E). Each requester issues one byte transaction at a time over a req/ack handshake. The arbiter selects one owner, forwards that owner's command to the downstream controller, and routes the acknowledge and read data back. Fairness is round-robin, with an optional bounded lock so the engine can keep the SRAM across consecutive row accesses.

---
 rtl/sram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one QSPI SRAM controller between the host bridge (H)
// and the Levenshtein engine (E). One byte transaction per req/ack handshake,
// round-robin on ties, and an optional lock that lets the current owner keep
// the SRAM for up to MAX_LOCK back-to-back transactions.
module sram_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  h_req,
    input  logic                  h_lock,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_ack,
    output logic [DATA_WIDTH-1:0] h_rdata,

    input  logic                  e_req,
    input  logic                  e_lock,
    input  logic                  e_we,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    input  logic [DATA_WIDTH-1:0] e_wdata,
    output logic                  e_ack,
    output logic [DATA_WIDTH-1:0] e_rdata,

    output logic                  dn_cyc,
    output logic                  dn_we,
    output logic [ADDR_WIDTH-1:0] dn_addr,
    output logic [DATA_WIDTH-1:0] dn_wdata,
    input  logic                  dn_ack,
    input  logic [DATA_WIDTH-1:0] dn_rdata,

    output logic [1:0]            grant
);

    // Port index 0 is the host, 1 is the engine; owner/last hold this index.
    localparam int        NP     = 2;
    localparam logic      PORT_H = 1'b0;
    localparam logic      PORT_E = 1'b1;
    localparam logic [8:0] LOCK_LIMIT = 9'(MAX_LOCK);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Per-port views of the requester inputs so the owner can index them.
    logic [NP-1:0]         req;
    logic [NP-1:0]         lock;
    logic [NP-1:0]         we;
    logic [ADDR_WIDTH-1:0] addr  [NP];
    logic [DATA_WIDTH-1:0] wdata [NP];
    logic [NP-1:0]         ack;
    logic [DATA_WIDTH-1:0] rdata [NP];

    assign req[0]   = h_req;
    assign req[1]   = e_req;
    assign lock[0]  = h_lock;
    assign lock[1]  = e_lock;
    assign we[0]    = h_we;
    assign we[1]    = e_we;
    assign addr[0]  = h_addr;
    assign addr[1]  = e_addr;
    assign wdata[0] = h_wdata;
    assign wdata[1] = e_wdata;

    state_t      state_q,    state_d;
    logic        owner_q,    owner_d;
    logic        last_q,     last_d;
    logic [7:0]  lock_cnt_q, lock_cnt_d;
    logic        dn_cyc_q,   dn_cyc_d;
    logic [1:0]  grant_q,    grant_d;

    // True when one more locked transaction still leaves us under the limit.
    logic lock_room;
    assign lock_room = ({1'b0, lock_cnt_q} + 9'd1) < LOCK_LIMIT;

    // Next-state logic: arbitration in IDLE, completion in BUSY, lock wait in HOLD.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req[0] || req[1]) begin
                    state_d    = ST_BUSY;
                    lock_cnt_d = 8'd0;
                    if (req[0] && req[1]) begin
                        // Tie: whoever did not finish last goes first.
                        owner_d = ~last_q;
                    end else begin
                        owner_d = req[1] ? PORT_E : PORT_H;
                    end
                end
            end
            ST_BUSY: begin
                // The transaction stays open until the controller answers,
                // even if the requester misbehaves and drops req.
                if (dn_ack) begin
                    last_d     = owner_q;
                    lock_cnt_d = lock_cnt_q + 8'd1;
                    if (lock[owner_q] && lock_room) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                // A fresh request wins even if lock fell in the same cycle.
                if (req[owner_q]) begin
                    state_d = ST_BUSY;
                end else if (!lock[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs follow the next state so they are registered, not decoded.
    always_comb begin
        dn_cyc_d = (state_d == ST_BUSY);
        grant_d  = 2'b00;
        if (state_d != ST_IDLE) begin
            grant_d = (owner_d == PORT_E) ? 2'b10 : 2'b01;
        end
    end

    // State and registered outputs; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= PORT_H;
            last_q     <= PORT_E;
            lock_cnt_q <= 8'd0;
            dn_cyc_q   <= 1'b0;
            grant_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            dn_cyc_q   <= dn_cyc_d;
            grant_q    <= grant_d;
        end
    end

    // Downstream command is the owner's inputs, quiet when no cycle is open.
    assign dn_cyc   = dn_cyc_q;
    assign dn_we    = dn_cyc_q & we[owner_q];
    assign dn_addr  = dn_cyc_q ? addr[owner_q]  : '0;
    assign dn_wdata = dn_cyc_q ? wdata[owner_q] : '0;
    assign grant    = grant_q;

    // Zero-latency ack/data return, only to the owner of an open cycle.
    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            assign ack[gi]   = dn_cyc_q && dn_ack && (owner_q == 1'(gi));
            assign rdata[gi] = ack[gi] ? dn_rdata : '0;
        end
    endgenerate

    assign h_ack   = ack[0];
    assign e_ack   = ack[1];
    assign h_rdata = rdata[0];
    assign e_rdata = rdata[1];

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: cycle-by-cycle vector table plus a hand-written
// reset-during-transaction sequence for sram_arbiter (MAX_LOCK = 4).
module tb_sram_arbiter;

    localparam logic [23:0] H_ADDR  = 24'h000123;
    localparam logic        H_WE    = 1'b0;
    localparam logic [7:0]  H_WDATA = 8'h11;
    localparam logic [23:0] E_ADDR  = 24'h00FFFF;
    localparam logic        E_WE    = 1'b1;
    localparam logic [7:0]  E_WDATA = 8'h5A;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req, h_lock, h_we, e_req, e_lock, e_we;
    logic [23:0] h_addr, e_addr, dn_addr;
    logic [7:0]  h_wdata, e_wdata, h_rdata, e_rdata, dn_wdata, dn_rdata;
    logic        h_ack, e_ack, dn_cyc, dn_we, dn_ack;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_WIDTH(24),
        .DATA_WIDTH(8),
        .MAX_LOCK  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .h_req   (h_req),
        .h_lock  (h_lock),
        .h_we    (h_we),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_ack   (h_ack),
        .h_rdata (h_rdata),
        .e_req   (e_req),
        .e_lock  (e_lock),
        .e_we    (e_we),
        .e_addr  (e_addr),
        .e_wdata (e_wdata),
        .e_ack   (e_ack),
        .e_rdata (e_rdata),
        .dn_cyc  (dn_cyc),
        .dn_we   (dn_we),
        .dn_addr (dn_addr),
        .dn_wdata(dn_wdata),
        .dn_ack  (dn_ack),
        .dn_rdata(dn_rdata),
        .grant   (grant)
    );

    typedef struct {
        logic       rst;
        logic       hr;
        logic       hl;
        logic       er;
        logic       el;
        logic       dack;
        logic [7:0] drd;
        logic       cyc;
        logic [1:0] gnt;
        logic       hack;
        logic       eack;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst_v, hr, hl, er, el, dack,
                                input logic [7:0] drd, input logic cyc,
                                input logic [1:0] gnt, input logic hack, eack);
        vec_t v;
        v.rst = rst_v; v.hr = hr; v.hl = hl; v.er = er; v.el = el;
        v.dack = dack; v.drd = drd; v.cyc = cyc; v.gnt = gnt;
        v.hack = hack; v.eack = eack;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        rst      = v.rst;
        h_req    = v.hr;
        h_lock   = v.hl;
        e_req    = v.er;
        e_lock   = v.el;
        dn_ack   = v.dack;
        dn_rdata = v.drd;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        logic [7:0] exp_hrd;
        logic [7:0] exp_erd;
        exp_hrd = v.hack ? v.drd : 8'h00;
        exp_erd = v.eack ? v.drd : 8'h00;
        check($sformatf("row%0d dn_cyc", i), 32'(dn_cyc), 32'(v.cyc));
        check($sformatf("row%0d grant", i),  32'(grant),  32'(v.gnt));
        check($sformatf("row%0d h_ack", i),  32'(h_ack),  32'(v.hack));
        check($sformatf("row%0d e_ack", i),  32'(e_ack),  32'(v.eack));
        check($sformatf("row%0d h_rdata", i), 32'(h_rdata), 32'(exp_hrd));
        check($sformatf("row%0d e_rdata", i), 32'(e_rdata), 32'(exp_erd));
        if (v.cyc) begin
            check($sformatf("row%0d dn_addr", i),  32'(dn_addr),
                  32'((v.gnt == 2'b01) ? H_ADDR : E_ADDR));
            check($sformatf("row%0d dn_we", i),    32'(dn_we),
                  32'((v.gnt == 2'b01) ? H_WE : E_WE));
            check($sformatf("row%0d dn_wdata", i), 32'(dn_wdata),
                  32'((v.gnt == 2'b01) ? H_WDATA : E_WDATA));
        end
        $display("row %0d: rst=%0b hreq=%0b ereq=%0b elock=%0b dn_ack=%0b -> dn_cyc=%0b grant=%0b h_ack=%0b e_ack=%0b",
                 i, v.rst, v.hr, v.er, v.el, v.dack, dn_cyc, grant, h_ack, e_ack);
    endtask

    task automatic add_busy(input int n, input logic hr, er, el, input logic [1:0] gnt);
        for (int k = 0; k < n; k++) tbl.push_back(mk(0, hr, 0, er, el, 0, 8'h00, 1, gnt, 0, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; h_req = 0; h_lock = 0; e_req = 0; e_lock = 0;
        dn_ack = 0; dn_rdata = 8'h00;
        h_we = H_WE; h_addr = H_ADDR; h_wdata = H_WDATA;
        e_we = E_WE; e_addr = E_ADDR; e_wdata = E_WDATA;

        // Reset held with h_req high and dn_ack pulsing; then first grant to H.
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 8'h55, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 8'h66, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 1, 2'b01, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h3C, 1, 2'b01, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        // Single H read of 0x000123, ack with A5 at cycle 5.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        add_busy(4, 1, 0, 0, 2'b01);
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'hA5, 1, 2'b01, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'hFF, 0, 2'b00, 0, 0));
        // Tie with last = H: E, H, E, H; each dn_cyc 2 cycles after previous ack.
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        add_busy(3, 1, 1, 0, 2'b10);
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 8'hE1, 1, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        add_busy(3, 1, 1, 0, 2'b01);
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 8'hB2, 1, 2'b01, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        add_busy(3, 1, 1, 0, 2'b10);
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 8'hE3, 1, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        add_busy(3, 1, 1, 0, 2'b01);
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 8'hB4, 1, 2'b01, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        // Lock limit 4: four E transactions, then H, then E again.
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 1, 2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h01, 1, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h02, 1, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 8'h00, 0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h03, 1, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h04, 1, 2'b10, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h05, 1, 2'b01, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0, 8'h00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 8'h06, 1, 2'b10, 0, 1));
        // Lock release from HOLD with e_req low: IDLE, then pending H.
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'b10, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 8'h07, 1, 2'b01, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0));

        @(posedge clk);
        foreach (tbl[i]) begin
            #1;
            apply(tbl[i]);
            @(negedge clk);
            check_vec(i, tbl[i]);
            @(posedge clk);
        end

        // Reset in the middle of an E write to 0x00FFFF, then a late dn_ack.
        #1; e_req = 1'b1; e_lock = 1'b0; h_req = 1'b0; dn_ack = 1'b0;
        @(negedge clk);
        check("rstbusy idle dn_cyc", 32'(dn_cyc), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstbusy busy dn_cyc", 32'(dn_cyc), 32'd1);
        check("rstbusy grant", 32'(grant), 32'h2);
        check("rstbusy dn_we", 32'(dn_we), 32'd1);
        check("rstbusy dn_addr", 32'(dn_addr), 32'h00FFFF);
        check("rstbusy dn_wdata", 32'(dn_wdata), 32'h5A);
        $display("rstbusy: E write open dn_cyc=%0b dn_addr=%06h", dn_cyc, dn_addr);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstbusy e_ack during rst", 32'(e_ack), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; e_req = 1'b0; dn_ack = 1'b1; dn_rdata = 8'h77;
        @(negedge clk);
        check("rstbusy dn_cyc after rst", 32'(dn_cyc), 32'd0);
        check("rstbusy grant after rst", 32'(grant), 32'h0);
        check("rstbusy late ack e_ack", 32'(e_ack), 32'd0);
        check("rstbusy late ack e_rdata", 32'(e_rdata), 32'd0);
        check("rstbusy late ack h_ack", 32'(h_ack), 32'd0);
        $display("rstbusy: late dn_ack after reset dn_cyc=%0b e_ack=%0b", dn_cyc, e_ack);
        @(posedge clk); #1;
        dn_ack = 1'b0; h_req = 1'b1; e_req = 1'b1;
        @(negedge clk);
        check("postrst tie idle dn_cyc", 32'(dn_cyc), 32'd0);
        @(posedge clk); #1;
        dn_ack = 1'b1; dn_rdata = 8'h9C;
        @(negedge clk);
        check("postrst tie grant H", 32'(grant), 32'h1);
        check("postrst h_ack", 32'(h_ack), 32'd1);
        check("postrst h_rdata", 32'(h_rdata), 32'h9C);
        check("postrst e_ack", 32'(e_ack), 32'd0);
        $display("postrst: tie after reset grant=%0b h_ack=%0b h_rdata=%02h", grant, h_ack, h_rdata);
        @(posedge clk); #1;
        dn_ack = 1'b0; h_req = 1'b0; e_req = 1'b0;
        @(negedge clk);
        check("postrst final dn_cyc", 32'(dn_cyc), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
